// File: rtl/seg_scan_capture.sv
// ============================================================================
// Module   : seg_scan_capture
// Purpose  : Rebuilds eight multiplexed seven-segment digit codes from a
//            scan bus, flagging scan-order errors and loss of scanning.
//            Optional hex decode outputs when SEG_CAP_DECODE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_capture #(
    parameter int          STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 60000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr_err,
    input  logic [2:0]  seg_sel_in,
    input  logic [7:0]  seg_data_in,
    output logic [63:0] digits,
    output logic        frame_valid,
    output logic [15:0] frame_cnt,
    output logic        seq_err,
    output logic        err_sticky,
`ifdef SEG_CAP_DECODE_EN
    output logic [31:0] digit_hex,
    output logic [7:0]  digit_dp,
    output logic [7:0]  decode_err,
`endif
    output logic        no_signal
);

    localparam logic [7:0]  c_STABLE  = 8'(STABLE_CYCLES);
    localparam logic [31:0] c_TIMEOUT = 32'(TIMEOUT_CYCLES);

    logic [2:0]  r_sel_m, r_sel_s, r_sel_q;
    logic [7:0]  r_data_m, r_data_s, r_data_q;
    logic [7:0]  r_stab_cnt;
    logic [63:0] r_shadow;
    logic [7:0]  r_seen;
    logic [2:0]  r_last_sel;
    logic        r_have_prev;
    logic [31:0] r_wd_cnt;
    logic        r_frame_pend;
    logic [63:0] r_digits;
    logic        r_frame_valid;
    logic [15:0] r_frame_cnt;
    logic        r_seq_err;
    logic        r_err_sticky;
    logic        r_no_signal;

    logic        w_changed;
    logic        w_cap;
    logic        w_order_err;
    logic [7:0]  w_seen_new;

    // Two-flop synchronizer plus a one-cycle history for change detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_m  <= 3'd0;
            r_sel_s  <= 3'd0;
            r_sel_q  <= 3'd0;
            r_data_m <= 8'd0;
            r_data_s <= 8'd0;
            r_data_q <= 8'd0;
        end else begin
            r_sel_m  <= seg_sel_in;
            r_sel_s  <= r_sel_m;
            r_sel_q  <= r_sel_s;
            r_data_m <= seg_data_in;
            r_data_s <= r_data_m;
            r_data_q <= r_data_s;
        end
    end

    always_comb begin
        w_changed   = {r_sel_s, r_data_s} != {r_sel_q, r_data_q};
        w_cap       = en && !w_changed && (r_stab_cnt == c_STABLE - 8'd1);
        w_order_err = r_have_prev && (r_sel_s != r_last_sel + 3'd1) && (r_sel_s != r_last_sel);
        w_seen_new  = (w_order_err ? 8'h00 : r_seen) | (8'h01 << r_sel_s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stab_cnt <= 8'd0;
        end else if (!en || w_changed) begin
            r_stab_cnt <= 8'd0;
        end else if (r_stab_cnt != c_STABLE) begin
            r_stab_cnt <= r_stab_cnt + 8'd1;
        end
    end

`ifdef SEG_CAP_DECODE_EN
    // Returns {err, nibble}; the dp bit is not part of the lookup
    function automatic logic [4:0] f_decode(input logic [6:0] code);
        case (code)
            7'h40:   return 5'h00;
            7'h79:   return 5'h01;
            7'h24:   return 5'h02;
            7'h30:   return 5'h03;
            7'h19:   return 5'h04;
            7'h12:   return 5'h05;
            7'h02:   return 5'h06;
            7'h78:   return 5'h07;
            7'h00:   return 5'h08;
            7'h10:   return 5'h09;
            7'h08:   return 5'h0A;
            7'h03:   return 5'h0B;
            7'h46:   return 5'h0C;
            7'h21:   return 5'h0D;
            7'h06:   return 5'h0E;
            7'h0E:   return 5'h0F;
            default: return 5'h10;
        endcase
    endfunction

    logic [7:0][4:0] w_dec;
    logic [31:0]     r_hex;
    logic [7:0]      r_dp;
    logic [7:0]      r_dec_err;

    for (genvar gk = 0; gk < 8; gk++) begin : g_dec
        assign w_dec[gk] = f_decode(r_shadow[8*gk +: 7]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex     <= 32'd0;
            r_dp      <= 8'd0;
            r_dec_err <= 8'd0;
        end else if (r_frame_pend && en) begin
            for (int k = 0; k < 8; k++) begin
                r_hex[4*k +: 4] <= w_dec[k][3:0];
                r_dec_err[k]    <= w_dec[k][4];
                r_dp[k]         <= ~r_shadow[8*k + 7];
            end
        end
    end

    assign digit_hex  = r_hex;
    assign digit_dp   = r_dp;
    assign decode_err = r_dec_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow      <= {64{1'b1}};
            r_seen        <= 8'h00;
            r_last_sel    <= 3'd0;
            r_have_prev   <= 1'b0;
            r_wd_cnt      <= 32'd0;
            r_frame_pend  <= 1'b0;
            r_digits      <= {64{1'b1}};
            r_frame_valid <= 1'b0;
            r_frame_cnt   <= 16'd0;
            r_seq_err     <= 1'b0;
            r_no_signal   <= 1'b1;
        end else begin
            r_seq_err     <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_pend  <= 1'b0;

            // Shadow already holds the closing byte one edge after its capture
            if (r_frame_pend && en) begin
                r_digits      <= r_shadow;
                r_frame_valid <= 1'b1;
                r_frame_cnt   <= r_frame_cnt + 16'd1;
            end

            if (!en) begin
                r_seen      <= 8'h00;
                r_have_prev <= 1'b0;
                r_wd_cnt    <= 32'd0;
            end else if (w_cap) begin
                r_shadow[{r_sel_s, 3'b000} +: 8] <= r_data_s;
                r_wd_cnt    <= 32'd0;
                r_no_signal <= 1'b0;
                r_last_sel  <= r_sel_s;
                r_have_prev <= 1'b1;
                r_seq_err   <= w_order_err;
                if (r_sel_s == 3'd7) begin
                    r_seen       <= 8'h00;
                    r_frame_pend <= (w_seen_new == 8'hFF);
                end else begin
                    r_seen <= w_seen_new;
                end
            end else if (r_wd_cnt != c_TIMEOUT) begin
                r_wd_cnt <= r_wd_cnt + 32'd1;
                if (r_wd_cnt + 32'd1 == c_TIMEOUT) begin
                    r_no_signal <= 1'b1;
                    r_seen      <= 8'h00;
                    r_have_prev <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sticky <= 1'b0;
        end else if (w_cap && w_order_err) begin
            r_err_sticky <= 1'b1;
        end else if (clr_err) begin
            r_err_sticky <= 1'b0;
        end
    end

    assign digits      = r_digits;
    assign frame_valid = r_frame_valid;
    assign frame_cnt   = r_frame_cnt;
    assign seq_err     = r_seq_err;
    assign err_sticky  = r_err_sticky;
    assign no_signal   = r_no_signal;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_capture.sv
// ============================================================================
// Module   : tb_seg_scan_capture
// Purpose  : Directed self-checking bench for seg_scan_capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_capture;

    localparam int c_STABLE  = 16;
    localparam int c_TIMEOUT = 2000;
    localparam int c_DWELL   = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clr_err;
    logic [2:0]  seg_sel_in;
    logic [7:0]  seg_data_in;
    logic [63:0] digits;
    logic        frame_valid;
    logic [15:0] frame_cnt;
    logic        seq_err;
    logic        err_sticky;
    logic        no_signal;
`ifdef SEG_CAP_DECODE_EN
    logic [31:0] digit_hex;
    logic [7:0]  digit_dp;
    logic [7:0]  decode_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_fv     = 0;
    int n_se     = 0;

    logic [7:0] tbl_a [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    logic [7:0] tbl_b [8] = '{8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E, 8'h80, 8'h90};

    seg_scan_capture #(
        .STABLE_CYCLES  (c_STABLE),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .clr_err     (clr_err),
        .seg_sel_in  (seg_sel_in),
        .seg_data_in (seg_data_in),
        .digits      (digits),
        .frame_valid (frame_valid),
        .frame_cnt   (frame_cnt),
        .seq_err     (seq_err),
        .err_sticky  (err_sticky),
`ifdef SEG_CAP_DECODE_EN
        .digit_hex   (digit_hex),
        .digit_dp    (digit_dp),
        .decode_err  (decode_err),
`endif
        .no_signal   (no_signal)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) n_fv++;
        if (seq_err)     n_se++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic dwell(input logic [2:0] sel, input logic [7:0] data, input int cycles);
        seg_sel_in  = sel;
        seg_data_in = data;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic sweep(input logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7);
        dwell(3'd0, d0, c_DWELL);
        dwell(3'd1, d1, c_DWELL);
        dwell(3'd2, d2, c_DWELL);
        dwell(3'd3, d3, c_DWELL);
        dwell(3'd4, d4, c_DWELL);
        dwell(3'd5, d5, c_DWELL);
        dwell(3'd6, d6, c_DWELL);
        dwell(3'd7, d7, c_DWELL);
    endtask

    initial begin
        int fv0, se0, k;
        rst_n       = 1'b0;
        en          = 1'b0;
        clr_err     = 1'b0;
        seg_sel_in  = 3'd0;
        seg_data_in = 8'hFF;
        repeat (4) @(negedge clk);
        check("rst_digits",      digits,      64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_frame_cnt",   frame_cnt,   0);
        check("rst_err_sticky",  err_sticky,  0);
        check("rst_no_signal",   no_signal,   1);
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;

        // Clean in-order sweep
        sweep(tbl_a[0], tbl_a[1], tbl_a[2], tbl_a[3], tbl_a[4], tbl_a[5], tbl_a[6], tbl_a[7]);
        check("t1_frames",    n_fv,      1);
        check("t1_digits",    digits,    64'hF882_9299_B0A4_F9C0);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_seq_err",   n_se,      0);
        check("t1_no_signal", no_signal, 0);

        // Short glitch during the sel=1 dwell must be filtered out
        fv0 = n_fv; se0 = n_se;
        dwell(3'd0, tbl_a[0], c_DWELL);
        dwell(3'd1, tbl_a[1], 100);
        dwell(3'd3, tbl_a[3], 5);
        dwell(3'd1, tbl_a[1], 100);
        for (int i = 2; i < 8; i++) dwell(3'(i), tbl_a[i], c_DWELL);
        check("t2_frames",    n_fv - fv0, 1);
        check("t2_seq_err",   n_se - se0, 0);
        check("t2_frame_cnt", frame_cnt,  2);

        // Skipped digits: 0,1,2,5,6,7
        fv0 = n_fv; se0 = n_se;
        dwell(3'd0, tbl_a[0], c_DWELL);
        dwell(3'd1, tbl_a[1], c_DWELL);
        dwell(3'd2, tbl_a[2], c_DWELL);
        dwell(3'd5, tbl_a[5], c_DWELL);
        dwell(3'd6, tbl_a[6], c_DWELL);
        dwell(3'd7, tbl_a[7], c_DWELL);
        check("t3_seq_err",    n_se - se0, 1);
        check("t3_sticky_set", err_sticky, 1);
        check("t3_no_frame",   n_fv - fv0, 0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        check("t3_sticky_clr", err_sticky, 0);

        // Recovery sweep; the sel=7 dwell is left open for the watchdog
        fv0 = n_fv; se0 = n_se;
        for (int i = 0; i < 7; i++) dwell(3'(i), tbl_b[i], c_DWELL);
        seg_sel_in  = 3'd7;
        seg_data_in = tbl_b[7];
        k = 0;
        while (!frame_valid && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("t3_fv_seen", frame_valid, 1);
        check("t3_digits",  digits,      64'h9080_8E86_A1C6_8388);
        check("t3_seq_err", n_se - se0,  0);

        // Watchdog: static bus after the last capture
        k = 0;
        while (!no_signal && k < c_TIMEOUT + 100) begin
            @(negedge clk);
            k++;
        end
        check("t4_timeout_cycle", k, c_TIMEOUT - 1);
        fv0 = n_fv; se0 = n_se;
        for (int i = 4; i < 8; i++) dwell(3'(i), tbl_a[i], c_DWELL);
        check("t4_no_signal_clr", no_signal,  0);
        check("t4_no_seq_err",    n_se - se0, 0);
        check("t4_no_partial",    n_fv - fv0, 0);
        sweep(tbl_a[0], tbl_a[1], tbl_a[2], tbl_a[3], tbl_a[4], tbl_a[5], tbl_a[6], tbl_a[7]);
        check("t4_frame", n_fv - fv0, 1);

        // Enable dropped mid-frame; resume at a non-consecutive digit
        fv0 = n_fv; se0 = n_se;
        for (int i = 0; i < 4; i++) dwell(3'(i), tbl_b[i], c_DWELL);
        en = 1'b0;
        seg_sel_in = 3'd5;
        seg_data_in = tbl_b[5];
        repeat (50) @(negedge clk);
        check("t5_cnt_hold", frame_cnt, 4);
        en = 1'b1;
        for (int i = 5; i < 8; i++) dwell(3'(i), tbl_b[i], c_DWELL);
        check("t5_no_seq_err", n_se - se0, 0);
        check("t5_no_frame",   n_fv - fv0, 0);
        check("t5_digits_hold", digits, 64'hF882_9299_B0A4_F9C0);
        sweep(tbl_b[0], tbl_b[1], tbl_b[2], tbl_b[3], tbl_b[4], tbl_b[5], tbl_b[6], tbl_b[7]);
        check("t5_frame",  n_fv - fv0, 1);
        check("t5_digits", digits,     64'h9080_8E86_A1C6_8388);

`ifdef SEG_CAP_DECODE_EN
        sweep(8'hC0, 8'hF9, 8'h24, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8);
        check("t6_hex",     digit_hex,  32'h7654_3210);
        check("t6_dp",      digit_dp,   8'h04);
        check("t6_err",     decode_err, 8'h00);
        sweep(8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hFF);
        check("t6_err_d7",  decode_err, 8'h80);
        check("t6_hex_d7",  digit_hex,  32'h0654_3210);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
